pipe_exe_sched: RTL and testbench

- Hazard and sequencing controller for the EXE stage of the 5-stage pipeline.
- Keeps shadow copies of the E and M stage destination and control fields.
- Generates operand forwarding selects for the ID stage, and stalls ID for load-use hazards.
- Holds EXE for a configurable number of cycles when a multi-cycle multiply/divide (MDU) op occupies it; EXE writes the MDU result onto ealu.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/pipe_exe_sched_if.sv | 31 +++
 rtl/fwd_sel.sv | 35 +++
 rtl/pipe_exe_sched.sv | 106 ++++++++++
 tb/tb_pipe_exe_sched.sv | 139 +++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: forwarding select encodings and the per-stage
// control fields carried alongside each instruction.
package pipe_pkg;

  localparam logic [1:0] FWD_REG  = 2'b00;
  localparam logic [1:0] FWD_EALU = 2'b01;
  localparam logic [1:0] FWD_MALU = 2'b10;
  localparam logic [1:0] FWD_MMO  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       mdu;
    logic [4:0] rn;
  } stage_ctl_t;

endpackage

// File: rtl/pipe_exe_sched_if.sv
// ID-stage request fields and the scheduler's hazard/sequencing responses.
interface pipe_exe_sched_if;

  logic [4:0] drs;
  logic [4:0] drt;
  logic       duse_rs;
  logic       duse_rt;
  logic       dwreg;
  logic       dm2reg;
  logic [4:0] drn;
  logic       dmdu;

  logic [1:0] fwda;
  logic [1:0] fwdb;
  logic       wpcir;
  logic       ebubble;
  logic       ehold;
  logic       mdu_busy;
  logic       mdu_done;

  modport master (
    output drs, drt, duse_rs, duse_rt, dwreg, dm2reg, drn, dmdu,
    input  fwda, fwdb, wpcir, ebubble, ehold, mdu_busy, mdu_done
  );

  modport slave (
    input  drs, drt, duse_rs, duse_rt, dwreg, dm2reg, drn, dmdu,
    output fwda, fwdb, wpcir, ebubble, ehold, mdu_busy, mdu_done
  );

endinterface

// File: rtl/fwd_sel.sv
// Operand forwarding select for one ID-stage source register.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       used,
  input  logic       e_wreg,
  input  logic       e_m2reg,
  input  logic [4:0] e_rn,
  input  logic       m_wreg,
  input  logic       m_m2reg,
  input  logic [4:0] m_rn,
  output logic [1:0] sel
);

  logic e_hit;
  logic m_hit;

  assign e_hit = used && (rs != REG_ZERO) && e_wreg && (e_rn == rs);
  assign m_hit = used && (rs != REG_ZERO) && m_wreg && (m_rn == rs);

  // A load in E cannot forward yet; in that case M is still allowed to supply
  // the operand, and the load-use stall covers the E dependency.
  always_comb begin
    sel = FWD_REG;
    if (e_hit && !e_m2reg) begin
      sel = FWD_EALU;
    end else if (m_hit && !m_m2reg) begin
      sel = FWD_MALU;
    end else if (m_hit && m_m2reg) begin
      sel = FWD_MMO;
    end
  end

endmodule

// File: rtl/pipe_exe_sched.sv
// EXE-stage hazard controller: forwarding selects, load-use stall and
// multi-cycle MDU hold, tracked through shadow copies of E and M control.
module pipe_exe_sched
  import pipe_pkg::*;
#(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CW      = 3
) (
  input  logic             clock,
  input  logic             reset,
  pipe_exe_sched_if.slave  bus
);

  localparam logic [CW-1:0] CNT_LOAD = CW'(MDU_LAT - 1);

  stage_ctl_t    d_ctl;
  stage_ctl_t    e_q, e_d;
  logic          m_wreg_q, m_wreg_d;
  logic          m_m2reg_q, m_m2reg_d;
  logic [4:0]    m_rn_q, m_rn_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic lu;
  logic hold;
  logic bubble;
  logic rs_dep;
  logic rt_dep;

  assign d_ctl = '{wreg: bus.dwreg, m2reg: bus.dm2reg, mdu: bus.dmdu, rn: bus.drn};

  assign hold   = e_q.mdu && (cnt_q != '0);
  assign rs_dep = bus.duse_rs && (e_q.rn == bus.drs);
  assign rt_dep = bus.duse_rt && (e_q.rn == bus.drt);
  assign lu     = e_q.wreg && e_q.m2reg && (e_q.rn != REG_ZERO) && (rs_dep || rt_dep);
  // An MDU hold freezes ID/EXE, so a pending load-use is simply re-evaluated later.
  assign bubble = lu && !hold;

  assign bus.mdu_busy = hold;
  assign bus.mdu_done = e_q.mdu && (cnt_q == '0);
  assign bus.ehold    = hold;
  assign bus.ebubble  = bubble;
  assign bus.wpcir    = !(hold || lu);

  fwd_sel u_fwd_a (
    .rs      (bus.drs),
    .used    (bus.duse_rs),
    .e_wreg  (e_q.wreg),
    .e_m2reg (e_q.m2reg),
    .e_rn    (e_q.rn),
    .m_wreg  (m_wreg_q),
    .m_m2reg (m_m2reg_q),
    .m_rn    (m_rn_q),
    .sel     (bus.fwda)
  );

  fwd_sel u_fwd_b (
    .rs      (bus.drt),
    .used    (bus.duse_rt),
    .e_wreg  (e_q.wreg),
    .e_m2reg (e_q.m2reg),
    .e_rn    (e_q.rn),
    .m_wreg  (m_wreg_q),
    .m_m2reg (m_m2reg_q),
    .m_rn    (m_rn_q),
    .sel     (bus.fwdb)
  );

  always_comb begin
    e_d       = e_q;
    m_wreg_d  = e_q.wreg;
    m_m2reg_d = e_q.m2reg;
    m_rn_d    = e_q.rn;
    cnt_d     = cnt_q;
    if (hold) begin
      m_wreg_d  = 1'b0;
      m_m2reg_d = 1'b0;
      m_rn_d    = REG_ZERO;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (bubble) begin
      e_d   = '0;
      cnt_d = '0;
    end else begin
      e_d   = d_ctl;
      cnt_d = bus.dmdu ? CNT_LOAD : '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      e_q       <= '0;
      m_wreg_q  <= 1'b0;
      m_m2reg_q <= 1'b0;
      m_rn_q    <= REG_ZERO;
      cnt_q     <= '0;
    end else begin
      e_q       <= e_d;
      m_wreg_q  <= m_wreg_d;
      m_m2reg_q <= m_m2reg_d;
      m_rn_q    <= m_rn_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_exe_sched.sv
// Directed instruction sequence for pipe_exe_sched; expected outputs are queued
// per cycle and checked by a separate monitor on the falling edge.
module tb_pipe_exe_sched;

  logic clock;
  logic reset;

  pipe_exe_sched_if bus ();

  pipe_exe_sched #(
    .MDU_LAT (4),
    .CW      (3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         id;
    logic [8:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  // exp packing: {fwda, fwdb, wpcir, ebubble, ehold, mdu_busy, mdu_done}
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t       e;
      logic [8:0] act;
      e   = exp_q.pop_front();
      act = {bus.fwda, bus.fwdb, bus.wpcir, bus.ebubble, bus.ehold, bus.mdu_busy,
             bus.mdu_done};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL vec%0d got fwda=%b fwdb=%b wpcir=%b ebubble=%b ehold=%b busy=%b done=%b want fwda=%b fwdb=%b wpcir=%b ebubble=%b ehold=%b busy=%b done=%b",
                 e.id, act[8:7], act[6:5], act[4], act[3], act[2], act[1], act[0],
                 e.exp[8:7], e.exp[6:5], e.exp[4], e.exp[3], e.exp[2], e.exp[1], e.exp[0]);
      end
    end
  end

  // Apply one cycle of ID-stage inputs and queue the outputs expected in that cycle.
  task automatic vec(input logic rst, input logic [4:0] rs, input logic urs,
                     input logic [4:0] rt, input logic urt, input logic wreg,
                     input logic m2reg, input logic [4:0] rn, input logic mdu,
                     input logic [1:0] fa, input logic [1:0] fb, input logic wp,
                     input logic eb, input logic eh, input logic bz, input logic dn);
    exp_t e;
    @(posedge clock);
    #1;
    reset       = rst;
    bus.drs     = rs;
    bus.duse_rs = urs;
    bus.drt     = rt;
    bus.duse_rt = urt;
    bus.dwreg   = wreg;
    bus.dm2reg  = m2reg;
    bus.drn     = rn;
    bus.dmdu    = mdu;
    e.id        = vec_id;
    e.exp       = {fa, fb, wp, eb, eh, bz, dn};
    exp_q.push_back(e);
    vec_id++;
  endtask

  initial begin
    reset       = 1'b1;
    bus.drs     = '0;
    bus.duse_rs = 1'b0;
    bus.drt     = '0;
    bus.duse_rt = 1'b0;
    bus.dwreg   = 1'b0;
    bus.dm2reg  = 1'b0;
    bus.drn     = '0;
    bus.dmdu    = 1'b0;
    repeat (2) @(posedge clock);

    //  rst rs  urs rt  urt wr ld rn   mdu   fa     fb     wp eb eh bz dn
    vec(1, 1,  1, 2,  1, 1, 0, 3,  0,  2'b00, 2'b00, 1, 0, 0, 0, 0); // reset state
    // ALU forwarding
    vec(0, 1,  1, 2,  1, 1, 0, 3,  0,  2'b00, 2'b00, 1, 0, 0, 0, 0); // add r3
    vec(0, 3,  1, 2,  1, 1, 0, 4,  0,  2'b01, 2'b00, 1, 0, 0, 0, 0); // sub r4 <- r3
    vec(0, 3,  1, 4,  1, 1, 0, 8,  0,  2'b10, 2'b01, 1, 0, 0, 0, 0); // or r8 <- r3,r4
    // Load-use
    vec(0, 1,  1, 8,  0, 1, 1, 5,  0,  2'b00, 2'b00, 1, 0, 0, 0, 0); // lw r5, rt unused
    vec(0, 7,  1, 5,  1, 1, 0, 6,  0,  2'b00, 2'b00, 0, 1, 0, 0, 0); // add r6 <- r5 stall
    vec(0, 7,  1, 5,  1, 1, 0, 6,  0,  2'b00, 2'b11, 1, 0, 0, 0, 0); // retry, mmo
    // R0 guard
    vec(0, 1,  1, 0,  0, 1, 1, 0,  0,  2'b00, 2'b00, 1, 0, 0, 0, 0); // lw r0
    vec(0, 0,  1, 0,  1, 1, 0, 9,  0,  2'b00, 2'b00, 1, 0, 0, 0, 0); // add r9 <- r0
    // Single MDU op plus dependent
    vec(0, 9,  1, 0,  1, 1, 0, 10, 1,  2'b01, 2'b00, 1, 0, 0, 0, 0); // mul r10 <- r9
    vec(0, 10, 1, 9,  1, 1, 0, 11, 0,  2'b01, 2'b10, 0, 0, 1, 1, 0); // add r11 hold 1
    vec(0, 10, 1, 9,  1, 1, 0, 11, 0,  2'b01, 2'b00, 0, 0, 1, 1, 0); // hold 2, M cleared
    vec(0, 10, 1, 9,  1, 1, 0, 11, 0,  2'b01, 2'b00, 0, 0, 1, 1, 0); // hold 3
    vec(0, 10, 1, 9,  1, 1, 0, 11, 0,  2'b01, 2'b00, 1, 0, 0, 0, 1); // done, advance
    vec(0, 10, 1, 11, 1, 1, 0, 12, 0,  2'b10, 2'b01, 1, 0, 0, 0, 0); // sub r12
    // Back-to-back MDU ops
    vec(0, 1,  1, 2,  1, 1, 0, 13, 1,  2'b00, 2'b00, 1, 0, 0, 0, 0); // mul r13
    vec(0, 13, 1, 12, 1, 1, 0, 14, 1,  2'b01, 2'b10, 0, 0, 1, 1, 0); // div r14 waits
    vec(0, 13, 1, 12, 1, 1, 0, 14, 1,  2'b01, 2'b00, 0, 0, 1, 1, 0);
    vec(0, 13, 1, 12, 1, 1, 0, 14, 1,  2'b01, 2'b00, 0, 0, 1, 1, 0);
    vec(0, 13, 1, 12, 1, 1, 0, 14, 1,  2'b01, 2'b00, 1, 0, 0, 0, 1); // enters on done
    vec(0, 14, 1, 13, 1, 1, 0, 15, 0,  2'b01, 2'b10, 0, 0, 1, 1, 0); // div busy at once
    vec(0, 14, 1, 13, 1, 1, 0, 15, 0,  2'b01, 2'b00, 0, 0, 1, 1, 0);
    vec(0, 14, 1, 13, 1, 1, 0, 15, 0,  2'b01, 2'b00, 0, 0, 1, 1, 0);
    vec(0, 14, 1, 13, 1, 1, 0, 15, 0,  2'b01, 2'b00, 1, 0, 0, 0, 1); // div done
    // MDU dependent on a load takes the bubble first
    vec(0, 1,  1, 2,  0, 1, 1, 17, 0,  2'b00, 2'b00, 1, 0, 0, 0, 0); // lw r17
    vec(0, 17, 1, 1,  1, 1, 0, 18, 1,  2'b00, 2'b00, 0, 1, 0, 0, 0); // mul r18 <- r17
    vec(0, 17, 1, 1,  1, 1, 0, 18, 1,  2'b11, 2'b00, 1, 0, 0, 0, 0); // enters EXE
    vec(0, 0,  0, 0,  0, 0, 0, 0,  0,  2'b00, 2'b00, 0, 0, 1, 1, 0); // cnt=3
    // Reset mid-op (cnt=2): abandoned with no done pulse
    vec(1, 0,  0, 0,  0, 0, 0, 0,  0,  2'b00, 2'b00, 0, 0, 1, 1, 0);
    vec(0, 3,  1, 4,  1, 0, 0, 0,  0,  2'b00, 2'b00, 1, 0, 0, 0, 0);
    vec(0, 0,  0, 0,  0, 0, 0, 0,  0,  2'b00, 2'b00, 1, 0, 0, 0, 0);
    vec(0, 0,  0, 0,  0, 0, 0, 0,  0,  2'b00, 2'b00, 1, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(negedge clock);
      #1;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
